// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage LC-3b pipeline: EX/MEM/WB tags, forwarding selects, stall/flush sequencing.
// Define HAZ_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_sr1,
    input  logic [2:0]       id_sr2,
    input  logic             id_use_sr1,
    input  logic             id_use_sr2,
    input  logic [2:0]       id_dest,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             br_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_if,
    output logic             stall_id,
    output logic             if_bubble,
    output logic             bubble_ex,
    output logic             freeze,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    typedef struct packed {
        logic       v;
        logic [2:0] dest;
        logic       rw;
        logic       ld;
    } tag_t;

    typedef struct packed {
        logic       v;
        logic [2:0] dest;
        logic       rw;
    } wb_tag_t;

    state_t  state_q, state_d;
    tag_t    ex_q, ex_d, mem_q, mem_d;
    wb_tag_t wb_q, wb_d;

    logic freeze_c, flush_c, lu_c, miss_c, load_use_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    function automatic logic tag_hit(input logic v, input logic rw,
                                     input logic [2:0] dest, input logic [2:0] r);
        return v & rw & (dest == r);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [2:0] r,
                                           input tag_t ex, input tag_t mem, input wb_tag_t wb);
        logic [1:0] sel;
        sel = 2'd0;
        if (use_src) begin
            if (tag_hit(ex.v, ex.rw, ex.dest, r))
                sel = 2'd1;
            else if (tag_hit(mem.v, mem.rw, mem.dest, r))
                sel = 2'd2;
            else if (tag_hit(wb.v, wb.rw, wb.dest, r))
                sel = 2'd3;
        end
        return sel;
    endfunction

    // Event detection with priority freeze > flush > load-use > fetch miss.
    always_comb begin
        load_use_c = id_valid & ex_q.ld &
                     ((id_use_sr1 & tag_hit(ex_q.v, ex_q.rw, ex_q.dest, id_sr1)) |
                      (id_use_sr2 & tag_hit(ex_q.v, ex_q.rw, ex_q.dest, id_sr2)));
        freeze_c   = dmem_req & ~dmem_resp;
        flush_c    = br_taken & mem_q.v & ~freeze_c;
        lu_c       = load_use_c & ~freeze_c & ~flush_c;
        miss_c     = ~imem_resp & ~freeze_c & ~flush_c & ~lu_c;
        fwd_a_c    = fwd_sel(id_use_sr1, id_sr1, ex_q, mem_q, wb_q);
        fwd_b_c    = fwd_sel(id_use_sr2, id_sr2, ex_q, mem_q, wb_q);
    end

    // Outputs are forced quiet while reset is held, since reset is asynchronous.
    always_comb begin
        fwd_a     = rst ? 2'd0 : fwd_a_c;
        fwd_b     = rst ? 2'd0 : fwd_b_c;
        freeze    = ~rst & freeze_c;
        flush     = ~rst & flush_c;
        stall_if  = ~rst & (freeze_c | lu_c);
        stall_id  = ~rst & (freeze_c | lu_c);
        bubble_ex = ~rst & lu_c;
        if_bubble = ~rst & (flush_c | miss_c);
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!freeze_c) begin
            wb_d  = '{v: mem_q.v, dest: mem_q.dest, rw: mem_q.rw};
            mem_d = flush_c ? '0 : ex_q;
            if (lu_c || flush_c || !id_valid)
                ex_d = '0;
            else
                ex_d = '{v: 1'b1, dest: id_dest, rw: id_regwrite, ld: id_is_load};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (freeze_c)
                    state_d = MEM_WAIT;
                else if (flush_c)
                    state_d = FLUSH;
                else if (lu_c)
                    state_d = LD_STALL;
            end
            MEM_WAIT: state_d = freeze_c ? MEM_WAIT : RUN;
            LD_STALL: state_d = RUN;
            FLUSH:    state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((freeze_c || lu_c) && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_c && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: forwarding, load-use, freeze, flush, fetch miss and async reset.
module tb_hazard_ctrl;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [2:0]       id_sr1, id_sr2, id_dest;
    logic             id_use_sr1, id_use_sr2, id_regwrite, id_is_load;
    logic             imem_resp, dmem_req, dmem_resp, br_taken;
    logic [1:0]       fwd_a, fwd_b;
    logic             stall_if, stall_id, if_bubble, bubble_ex, freeze, flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    typedef struct {
        string      tag;
        logic [9:0] vec;
    } exp_t;

    exp_t sb[$];
    int   checkCount = 0;
    int   failCount  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_sr1(id_sr1), .id_sr2(id_sr2),
        .id_use_sr1(id_use_sr1), .id_use_sr2(id_use_sr2),
        .id_dest(id_dest), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp), .br_taken(br_taken),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_if(stall_if), .stall_id(stall_id),
        .if_bubble(if_bubble), .bubble_ex(bubble_ex), .freeze(freeze), .flush(flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic applyStimulus(input logic v, input logic [2:0] s1, input logic [2:0] s2,
                                 input logic u1, input logic u2, input logic [2:0] d,
                                 input logic rw, input logic ld, input logic im,
                                 input logic dq, input logic dr, input logic br);
        id_valid = v;  id_sr1 = s1; id_sr2 = s2; id_use_sr1 = u1; id_use_sr2 = u2;
        id_dest = d;   id_regwrite = rw; id_is_load = ld;
        imem_resp = im; dmem_req = dq; dmem_resp = dr; br_taken = br;
    endtask

    // ctl = {stall_if, stall_id, if_bubble, bubble_ex, freeze, flush}
    task automatic expectOut(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                             input logic [5:0] ctl);
        exp_t e;
        e.tag = tag;
        e.vec = {fa, fb, ctl};
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic [9:0] obs;
        e   = sb.pop_front();
        obs = {fwd_a, fwd_b, stall_if, stall_id, if_bubble, bubble_ex, freeze, flush};
        checkCount++;
        assert (obs === e.vec) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.vec);
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [5:0] ctl);
        expectOut(tag, fa, fb, ctl);
        #2;
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        #3;
        expectOut("reset", 2'd0, 2'd0, 6'b000000);
        checkOutput();
        checkVal("reset_state", 32'(dut.state_q), 0);
        applyStimulus(1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 1);
        step("reset_busy_inputs", 2'd0, 2'd0, 6'b000000);

        @(negedge clk); rst = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        step("add_r1_issue", 2'd0, 2'd0, 6'b000000);
        @(negedge clk); applyStimulus(1, 1, 1, 1, 1, 3, 1, 0, 1, 0, 0, 0);
        step("fwd_ex_both", 2'd1, 2'd1, 6'b000000);
        @(negedge clk); applyStimulus(1, 1, 3, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        step("fwd_mem_ex", 2'd2, 2'd1, 6'b000000);
        @(negedge clk); applyStimulus(1, 1, 3, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        step("fwd_wb_mem", 2'd3, 2'd2, 6'b000000);
        @(negedge clk); applyStimulus(0, 3, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        step("fwd_wb_nouse", 2'd3, 2'd0, 6'b000000);

        @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 2, 1, 1, 1, 0, 0, 0);
        step("ldr_issue", 2'd0, 2'd0, 6'b000000);
        @(negedge clk); applyStimulus(1, 4, 2, 1, 1, 5, 1, 0, 1, 0, 0, 0);
        step("load_use", 2'd0, 2'd1, 6'b110100);
        @(negedge clk);
        step("ld_fwd_mem", 2'd0, 2'd2, 6'b000000);
        checkVal("state_ld_stall", 32'(dut.state_q), 1);
        @(negedge clk); applyStimulus(1, 2, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        step("fwd_wb_ex", 2'd3, 2'd1, 6'b000000);
        checkVal("state_run_after_ld", 32'(dut.state_q), 0);

        @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 2, 1, 1, 1, 0, 0, 0);
        step("ldr_issue2", 2'd0, 2'd0, 6'b000000);
        @(negedge clk); applyStimulus(1, 6, 2, 1, 0, 6, 0, 0, 1, 0, 0, 0);
        step("ld_nouse", 2'd0, 2'd0, 6'b000000);

        @(negedge clk); applyStimulus(1, 2, 0, 1, 0, 6, 0, 0, 0, 1, 0, 1);
        step("freeze_1", 2'd2, 2'd0, 6'b110010);
        @(negedge clk);
        step("freeze_2", 2'd2, 2'd0, 6'b110010);
        checkVal("state_mem_wait", 32'(dut.state_q), 2);
        @(negedge clk);
        step("freeze_3", 2'd2, 2'd0, 6'b110010);
        @(negedge clk); applyStimulus(1, 2, 0, 1, 0, 6, 0, 0, 1, 1, 1, 0);
        step("freeze_resp", 2'd2, 2'd0, 6'b000000);
        checkVal("state_mem_wait_resp", 32'(dut.state_q), 2);
        @(negedge clk); applyStimulus(1, 2, 0, 1, 0, 7, 1, 1, 1, 0, 0, 0);
        step("fwd_wb_after_freeze", 2'd3, 2'd0, 6'b000000);
        checkVal("state_run_after_freeze", 32'(dut.state_q), 0);
`ifdef HAZ_PERF_CNT_EN
        checkVal("stall_cnt_4", 32'(stall_cnt), 4);
        checkVal("flush_cnt_0", 32'(flush_cnt), 0);
`else
        checkVal("stall_cnt_tied", 32'(stall_cnt), 0);
`endif

        @(negedge clk); applyStimulus(1, 7, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1);
        step("flush_over_lu", 2'd1, 2'd0, 6'b001001);
        @(negedge clk); applyStimulus(0, 7, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("fetch_miss_after_flush", 2'd0, 2'd0, 6'b001000);
        checkVal("state_flush", 32'(dut.state_q), 3);
`ifdef HAZ_PERF_CNT_EN
        checkVal("flush_cnt_1", 32'(flush_cnt), 1);
`else
        checkVal("flush_cnt_tied", 32'(flush_cnt), 0);
`endif

        @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        step("add_r1_again", 2'd0, 2'd0, 6'b000000);
        @(negedge clk); applyStimulus(1, 1, 0, 1, 0, 2, 0, 0, 1, 1, 0, 0);
        step("freeze_pre_rst", 2'd1, 2'd0, 6'b110010);
        #1 rst = 1'b1;
        #1;
        expectOut("rst_mid_freeze", 2'd0, 2'd0, 6'b000000);
        checkOutput();
        checkVal("rst_state_run", 32'(dut.state_q), 0);
        checkVal("rst_stall_cnt", 32'(stall_cnt), 0);
        @(negedge clk); rst = 1'b0;
        applyStimulus(1, 1, 0, 1, 0, 2, 0, 0, 1, 0, 0, 0);
        step("tags_dropped", 2'd0, 2'd0, 6'b000000);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule
